// File: rtl/spi_target.sv
// SPI target (mode 0): mosi is assembled LSB first, miso is sent MSB first, with a single TX holding register.
// RX storage is one register by default; defining SPI_TARGET_RX_FIFO_EN makes it a 4-entry FIFO.
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  output logic       underrun,
  output logic       busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, ss_dly_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_dly_q  <= sclk_s;
      ss_dly_q    <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ss_rise   = ss_s & ~ss_dly_q;
  assign ss_fall   = ~ss_s & ss_dly_q;

  state_t     state_q, state_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, hold_q, hold_d;
  logic [2:0] cnt_q, cnt_d;
  logic       byte_done_q, byte_done_d, hold_full_q, hold_full_d;
  logic       underrun_q, underrun_d;
  logic       push, reload;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      byte_done_q <= 1'b0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      byte_done_q <= byte_done_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    byte_done_d = byte_done_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;
    push        = 1'b0;
    reload      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_rise) begin
          state_d = ACTIVE;
          reload  = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect wins over a coincident sclk edge: the in-flight byte is abandoned.
        if (ss_fall) begin
          state_d     = IDLE;
          tx_sh_d     = '0;
          rx_sh_d     = '0;
          cnt_d       = '0;
          byte_done_d = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_sh_d = {mosi_s, rx_sh_q[7:1]};
            cnt_d   = 3'(cnt_q + 3'd1);
            if (cnt_q == 3'd7) begin
              push        = 1'b1;
              byte_done_d = 1'b1;
            end
          end
          if (sclk_fall) begin
            if (byte_done_q) begin
              reload      = 1'b1;
              byte_done_d = 1'b0;
            end else begin
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (reload) begin
      if (hold_full_q) begin
        tx_sh_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sh_d    = '0;
        underrun_d = 1'b1;
      end
    end
    // Gated on the registered flag, so a load coinciding with a consume is dropped.
    if (tx_load && !hold_full_q) begin
      hold_d      = tx_byte;
      hold_full_d = 1'b1;
    end
  end

  assign miso     = (state_q == ACTIVE) ? tx_sh_q[7] : 1'b0;
  assign tx_ready = ~hold_full_q;
  assign underrun = underrun_q;
  assign busy     = ss_s;

  logic overrun_q, overrun_d;

`ifdef SPI_TARGET_RX_FIFO_EN
  logic [3:0][7:0] fifo_q;
  logic [1:0]      wr_q, rd_q;
  logic [2:0]      fcnt_q;
  logic            pop, wr_en;

  assign pop       = rx_ack && (fcnt_q != 3'd0);
  assign wr_en     = push && ((fcnt_q != 3'd4) || pop);
  assign overrun_d = push && !wr_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      fcnt_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) begin
        fifo_q[wr_q] <= rx_sh_d;
        wr_q         <= 2'(wr_q + 2'd1);
      end
      if (pop) rd_q <= 2'(rd_q + 2'd1);
      fcnt_q    <= 3'(fcnt_q + {2'b00, wr_en} - {2'b00, pop});
      overrun_q <= overrun_d;
    end
  end

  assign rx_byte  = fifo_q[rd_q];
  assign rx_valid = (fcnt_q != 3'd0);
`else
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;

  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (push) begin
      if (rx_valid_q && !rx_ack) begin
        overrun_d = 1'b1;
      end else begin
        rx_byte_d  = rx_sh_d;
        rx_valid_d = 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
`endif

  assign overrun = overrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: SPI mode 0 initiator driven from tasks, expected values hand-computed.
module tb_spi_target;
  localparam int HALF = 8;

  logic       clock, reset, sclk, ss, mosi, miso;
  logic [7:0] tx_byte, rx_byte;
  logic       tx_load, tx_ready, rx_valid, rx_ack, overrun, underrun, busy;

  int checks = 0;
  int failures = 0;
  int und_cnt = 0;
  int ovr_cnt = 0;

  spi_target #(.SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .tx_byte(tx_byte), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .overrun(overrun), .underrun(underrun), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (underrun === 1'b1) und_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_byte = b;
    tx_load = 1'b1;
    wait_clks(1);
    tx_load = 1'b0;
  endtask

  task automatic pop_rx(input string name, input logic [7:0] exp);
    checks++;
    if (rx_valid !== 1'b1 || rx_byte !== exp) begin
      failures++;
      $display("FAIL %s: rx_valid=%b rx_byte=%h, required 1 / %h", name, rx_valid, rx_byte, exp);
    end
    rx_ack = 1'b1;
    wait_clks(1);
    rx_ack = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] mo, input bit last, output logic [7:0] mi);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      mosi = mo[i];
      wait_clks(HALF);
      acc[7-i] = miso;
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
      if (last && i == 7) ss = 1'b0;
    end
    if (last) wait_clks(HALF);
    mi = acc;
  endtask

  task automatic xfer(input logic [7:0] mo, output logic [7:0] mi);
    ss = 1'b1;
    wait_clks(HALF);
    spi_byte(mo, 1'b1, mi);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_clks(3);
    checks++;
    if ({miso, tx_ready, rx_valid, rx_byte, overrun, underrun, busy} !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: miso=%b tx_ready=%b rx_valid=%b rx_byte=%h ovr=%b und=%b busy=%b, required 0 1 0 00 0 0 0",
               miso, tx_ready, rx_valid, rx_byte, overrun, underrun, busy);
    end
    reset = 1'b0;
    wait_clks(2);
    checks++;
    if (tx_ready !== 1'b1 || rx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: tx_ready=%b rx_valid=%b busy=%b, required 1 0 0", tx_ready, rx_valid, busy);
    end
  endtask

  task automatic test_basic;
    logic [7:0] mi;
    int u0;
    u0 = und_cnt;
    tx_byte = 8'hA5;
    tx_load = 1'b1;
    wait_clks(1);
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL tx_ready_fall: got %b required 0", tx_ready); end
    tx_byte = 8'hFF;
    wait_clks(1);
    tx_load = 1'b0;
    xfer(8'h3C, mi);
    checks++;
    if (mi !== 8'hA5) begin failures++; $display("FAIL basic_miso: got %h required a5", mi); end
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL basic_tx_ready: got %b required 1", tx_ready); end
    checks++;
    if (und_cnt - u0 !== 0) begin failures++; $display("FAIL basic_underrun: got %0d pulses required 0", und_cnt - u0); end
    pop_rx("basic_rx", 8'h3C);
    rx_ack = 1'b1;
    wait_clks(1);
    rx_ack = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL ack_when_empty: rx_valid=%b required 0", rx_valid); end
  endtask

  task automatic test_underrun;
    logic [7:0] mi;
    int u0;
    u0 = und_cnt;
    xfer(8'h5A, mi);
    checks++;
    if (mi !== 8'h00) begin failures++; $display("FAIL underrun_miso: got %h required 00", mi); end
    checks++;
    if (und_cnt - u0 !== 1) begin failures++; $display("FAIL underrun_pulses: got %0d required 1", und_cnt - u0); end
    pop_rx("underrun_rx", 8'h5A);
  endtask

  task automatic test_overrun;
    logic [7:0] mi;
    int o0;
    o0 = ovr_cnt;
`ifdef SPI_TARGET_RX_FIFO_EN
    for (int k = 1; k <= 5; k++) xfer(8'(k), mi);
    checks++;
    if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL fifo_overrun: got %0d pulses required 1", ovr_cnt - o0); end
    pop_rx("fifo_0", 8'h01);
    pop_rx("fifo_1", 8'h02);
    pop_rx("fifo_2", 8'h03);
    pop_rx("fifo_3", 8'h04);
`else
    xfer(8'h11, mi);
    xfer(8'h22, mi);
    checks++;
    if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL overrun_pulses: got %0d required 1", ovr_cnt - o0); end
    pop_rx("overrun_keep_first", 8'h11);
`endif
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL overrun_drained: rx_valid=%b required 0", rx_valid); end
  endtask

  task automatic test_ss_abort;
    logic [7:0] mi;
    ss = 1'b1;
    wait_clks(HALF);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      wait_clks(HALF);
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
    wait_clks(HALF);
    ss = 1'b0;
    wait_clks(HALF);
    checks++;
    if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_push: rx_valid=%b busy=%b required 0 0", rx_valid, busy);
    end
    xfer(8'h81, mi);
    pop_rx("abort_then_81", 8'h81);
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL abort_single_byte: rx_valid=%b required 0", rx_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] mi1, mi2;
    int u0, o0;
    u0 = und_cnt;
    o0 = ovr_cnt;
    load_tx(8'hC3);
    ss = 1'b1;
    wait_clks(HALF);
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL b2b_hold_consumed: tx_ready=%b required 1", tx_ready); end
    load_tx(8'h5A);
    spi_byte(8'h11, 1'b0, mi1);
    pop_rx("b2b_rx0", 8'h11);
    spi_byte(8'h22, 1'b1, mi2);
    checks++;
    if (mi1 !== 8'hC3 || mi2 !== 8'h5A) begin
      failures++;
      $display("FAIL b2b_miso: got %h %h required c3 5a", mi1, mi2);
    end
    checks++;
    if (und_cnt - u0 !== 0 || ovr_cnt - o0 !== 0) begin
      failures++;
      $display("FAIL b2b_pulses: underrun=%0d overrun=%0d required 0 0", und_cnt - u0, ovr_cnt - o0);
    end
    pop_rx("b2b_rx1", 8'h22);
  endtask

  task automatic test_reset_mid;
    logic [7:0] mi;
    int u0, o0;
    xfer(8'h44, mi);
    load_tx(8'hFF);
    ss = 1'b1;
    wait_clks(HALF);
    load_tx(8'h99);
    for (int e = 0; e < 5; e++) begin
      sclk = ~sclk;
      wait_clks(HALF);
    end
    checks++;
    if (busy !== 1'b1 || miso !== 1'b1 || tx_ready !== 1'b0 || rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_state: busy=%b miso=%b tx_ready=%b rx_valid=%b required 1 1 0 1", busy, miso, tx_ready, rx_valid);
    end
    reset = 1'b1;
    sclk = 1'b0;
    ss = 1'b0;
    wait_clks(1);
    checks++;
    if ({miso, tx_ready, rx_valid, rx_byte, overrun, underrun, busy} !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset_outputs: miso=%b tx_ready=%b rx_valid=%b rx_byte=%h ovr=%b und=%b busy=%b, required 0 1 0 00 0 0 0",
               miso, tx_ready, rx_valid, rx_byte, overrun, underrun, busy);
    end
    wait_clks(3);
    reset = 1'b0;
    wait_clks(2);
    u0 = und_cnt;
    o0 = ovr_cnt;
    load_tx(8'h3C);
    xfer(8'hA5, mi);
    checks++;
    if (mi !== 8'h3C) begin failures++; $display("FAIL post_reset_miso: got %h required 3c", mi); end
    checks++;
    if (und_cnt - u0 !== 0 || ovr_cnt - o0 !== 0) begin
      failures++;
      $display("FAIL post_reset_pulses: underrun=%0d overrun=%0d required 0 0", und_cnt - u0, ovr_cnt - o0);
    end
    pop_rx("post_reset_rx", 8'hA5);
  endtask

  initial begin
    reset = 1'b1; sclk = 1'b0; ss = 1'b0; mosi = 1'b0;
    tx_byte = '0; tx_load = 1'b0; rx_ack = 1'b0;
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_ss_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth on sclk, ss and mosi (legal range 2..4).
REQ-002 The block SHALL have the following ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- sclk, input, 1: SPI clock from the initiator; idles low.
- ss, input, 1: slave select; active high.
- mosi, input, 1: data from the initiator; LSB first.
- miso, output, 1: data to the initiator; MSB first.
- tx_byte, input, 8: next byte to send.
- tx_load, input, 1: one-cycle strobe capturing tx_byte.
- tx_ready, output, 1: TX holding register empty.
- rx_byte, output, 8: received byte, head of RX storage.
- rx_valid, output, 1: rx_byte holds unread data.
- rx_ack, input, 1: consumer pops rx_byte.
- overrun, output, 1: one-cycle pulse when a received byte is dropped.
- underrun, output, 1: one-cycle pulse when 0x00 is sent because TX was empty.
- busy, output, 1: synchronised ss is high.

Function
REQ-003 sclk, ss and mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected by comparing the last stage with one further registered copy.
REQ-004 Correct operation SHALL require sclk high and low phases each of at least SYNC_STAGES+2 clock periods; there is no requirement below that limit.
REQ-005 State machine: IDLE (ss_s low) and ACTIVE (ss_s high).
- IDLE->ACTIVE on ss_s rising.
- ACTIVE->IDLE on ss_s falling.
REQ-006 On ss_s rising, the TX shift register SHALL load from the holding register and mark it empty; if the holding register is empty, it SHALL load 0x00 and pulse underrun.
REQ-007 In ACTIVE, miso SHALL equal TX shift register bit 7 combinationally from the register; in IDLE, miso SHALL be 0.
REQ-008 On a detected sclk rising edge in ACTIVE:
- mosi_s SHALL shift into RX shift register bit 7 (right shift, LSB-first assembly).
- The bit counter (3 bits) SHALL increment.
REQ-009 On a detected sclk falling edge in ACTIVE, the TX shift register SHALL shift left by one, except after the 8th rising edge of a byte, when it SHALL instead reload per REQ-006.
REQ-010 On the 8th rising edge, the assembled byte SHALL be pushed to RX storage in the same cycle and the bit counter SHALL wrap to 0; rx_valid SHALL be visible one clock after edge detection.
REQ-011 ss_s falling mid-byte SHALL discard the partial RX byte and the loaded TX byte, and SHALL clear the counter; the holding register SHALL be unaffected.
REQ-012 tx_load SHALL capture tx_byte only when tx_ready=1; tx_load with tx_ready=0 SHALL be ignored. tx_ready SHALL fall the cycle after capture.
REQ-013 tx_load in the same cycle as a holding-register consume SHALL be ignored, because tx_ready was 0 in that cycle.
REQ-014 Single-register RX:
- rx_valid SHALL hold until rx_ack.
- A push while rx_valid=1 and rx_ack=0 SHALL drop the new byte and pulse overrun.
- A push with rx_ack=1 in the same cycle SHALL replace the byte and keep rx_valid=1.
REQ-015 rx_ack with rx_valid=0 SHALL have no effect.
REQ-016 Edges of sclk while IDLE SHALL be ignored.

Reset
REQ-017 While reset is high, all of the following SHALL be cleared: synchroniser flops, shift registers, counter, RX storage and the holding register.
REQ-018 Outputs during and after reset SHALL be: miso=0, tx_ready=1, rx_valid=0, rx_byte=0x00, overrun=0, underrun=0, busy=0.
REQ-019 Reset SHALL take priority over every other input, including mid-transaction.

Configuration
REQ-020 When macro SPI_TARGET_RX_FIFO_EN is defined, RX storage SHALL be a 4-entry FIFO:
- rx_valid SHALL be high when the FIFO is not empty.
- rx_byte SHALL be the FIFO head.
- rx_ack SHALL pop the head.
- A push when full SHALL drop the byte and pulse overrun, unless a pop occurs in the same cycle, in which case both SHALL succeed.
REQ-021 When SPI_TARGET_RX_FIFO_EN is undefined, RX storage SHALL be the single register of REQ-014.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Load 0xA5, then ss high, 8 sclk cycles with mosi LSB-first 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_byte=0x3C with rx_valid; tx_ready=1.
- Transaction with no tx_load -> miso all 0; one underrun pulse.
- Two bytes, no rx_ack, no FIFO -> first byte retained; one overrun pulse.
- With SPI_TARGET_RX_FIFO_EN: 5 bytes, no ack -> 4 stored, in order; one overrun.
- ss drops after 3 bits, then a full byte 0x81 -> only 0x81 received; counter restarted.
- Reset asserted after the 5th sclk edge -> all outputs at reset values the next cycle; the next transaction is clean.
